// File: rtl/sysinfo_pkg.sv
// sysinfo_pkg
// Shared constants for the system-info register block: word addresses,
// CTRL bit positions, reset values and a byte-lane merge helper.
package sysinfo_pkg;

  // Word addresses (compared against the zero-extended Avalon address)
  localparam logic [31:0] ADDR_ID       = 32'd0;
  localparam logic [31:0] ADDR_TS       = 32'd1;
  localparam logic [31:0] ADDR_UP_LO    = 32'd2;
  localparam logic [31:0] ADDR_UP_HI    = 32'd3;
  localparam logic [31:0] ADDR_CTRL     = 32'd4;
  localparam logic [31:0] ADDR_SCRATCH0 = 32'd5;

  // CTRL register bit indices
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // Reset values
  localparam logic        CTRL_RUN_RST = 1'b1;
  localparam logic [63:0] UPTIME_RST   = 64'h0;
  localparam logic [31:0] SHADOW_RST   = 32'h0;
  localparam logic [31:0] SCRATCH_RST  = 32'h0;
  localparam logic [31:0] RDATA_RST    = 32'h0;

  // Merge new data into old data on the byte lanes selected by be.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysinfo_uptime_counter.sv
// sysinfo_uptime_counter
// 64-bit free-running uptime counter with a 32-bit high-word shadow.
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-high reset
//   run       - count enable
//   clear     - zero counter and shadow this edge (wins over run)
//   snap      - load count[63:32] into the shadow this edge
//   count     - live 64-bit counter value
//   hi_shadow - high word captured on the last snap
module sysinfo_uptime_counter
  import sysinfo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        snap,
  output logic [63:0] count,
  output logic [31:0] hi_shadow
);

  logic [63:0] count_d, count_q;
  logic [31:0] hi_shadow_d, hi_shadow_q;

  always_comb begin
    count_d     = count_q;
    hi_shadow_d = hi_shadow_q;
    if (clear) begin
      count_d     = UPTIME_RST;
      hi_shadow_d = SHADOW_RST;
    end else begin
      // Wraps silently at 2^64-1.
      if (run)  count_d     = count_q + 64'd1;
      // Shadow takes the pre-increment sample so LO/HI form one coherent value.
      if (snap) hi_shadow_d = count_q[63:32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= UPTIME_RST;
      hi_shadow_q <= SHADOW_RST;
    end else begin
      count_q     <= count_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign count     = count_q;
  assign hi_shadow = hi_shadow_q;

endmodule

// File: rtl/first_nios2_system_sysinfo.sv
// first_nios2_system_sysinfo
// Avalon-MM slave exposing system ID, build timestamp, a 64-bit uptime
// counter (coherent LO/HI via shadow), a CTRL register and scratch words.
// Ports:
//   clock, reset              - clock, asynchronous active-high reset
//   address [ADDR_W-1:0]      - word address
//   read, write               - one-cycle strobes (read wins if both)
//   writedata [31:0]          - write data
//   byteenable [3:0]          - write byte lanes
//   readdata [31:0]           - registered read data, holds when not valid
//   readdatavalid             - one cycle, one clock after an accepted read
// 2**ADDR_W must be at least 5+NUM_SCRATCH; NUM_SCRATCH is 1..8.
module first_nios2_system_sysinfo
  import sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h5148_D8C5,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int          NUM_SCRATCH = 2,
  parameter int          ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0] addr_w;
  logic        wr_acc;
  logic        snap;
  logic        clear;
  logic [63:0] uptime;
  logic [31:0] hi_shadow;
  logic [31:0] rd_word;

  logic        run_d, run_q;
  logic [31:0] readdata_d, readdata_q;
  logic        readdatavalid_d, readdatavalid_q;
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] scratch_q [NUM_SCRATCH];

  assign addr_w = 32'(address);
  // A simultaneous write is dropped in favour of the read.
  assign wr_acc = write & ~read;
  assign snap   = read & (addr_w == ADDR_UP_LO);
  // Clear is a pulse derived directly from the write; it never persists.
  assign clear  = wr_acc & (addr_w == ADDR_CTRL) & byteenable[0]
                & writedata[CTRL_CLEAR_BIT];

  sysinfo_uptime_counter u_uptime (
    .clock     (clock),
    .reset     (reset),
    .run       (run_q),
    .clear     (clear),
    .snap      (snap),
    .count     (uptime),
    .hi_shadow (hi_shadow)
  );

  // Register write decode
  always_comb begin
    run_d = run_q;
    if (wr_acc && addr_w == ADDR_CTRL && byteenable[0])
      run_d = writedata[CTRL_RUN_BIT];
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (wr_acc && addr_w == ADDR_SCRATCH0 + 32'(i))
        scratch_d[i] = apply_be(scratch_q[i], writedata, byteenable);
    end
  end

  // Read mux; unmapped words return 0
  always_comb begin
    rd_word = 32'h0;
    if (addr_w == ADDR_ID)         rd_word = SYSTEM_ID;
    else if (addr_w == ADDR_TS)    rd_word = TIMESTAMP;
    else if (addr_w == ADDR_UP_LO) rd_word = uptime[31:0];
    else if (addr_w == ADDR_UP_HI) rd_word = hi_shadow;
    else if (addr_w == ADDR_CTRL)  rd_word = {31'h0, run_q};
    else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (addr_w == ADDR_SCRATCH0 + 32'(i)) rd_word = scratch_q[i];
      end
    end
  end

  always_comb begin
    readdata_d      = readdata_q;
    readdatavalid_d = read;
    if (read) readdata_d = rd_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q           <= CTRL_RUN_RST;
      readdata_q      <= RDATA_RST;
      readdatavalid_q <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= SCRATCH_RST;
    end else begin
      run_q           <= run_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;

endmodule

// File: doc/first_nios2_system_sysinfo.md
FIRST_NIOS2_SYSTEM_SYSINFO -- requirements
Module: first_nios2_system_sysinfo

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h5148_D8C5, value returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'h0, build time returned at word 1.
REQ-003 Parameter NUM_SCRATCH, default 2, range 1..8, count of R/W scratch words.
REQ-004 Parameter ADDR_W, default 4, word-address width; SHALL satisfy 2**ADDR_W >= 5+NUM_SCRATCH.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  ADDR_W  Avalon-MM word address.
REQ-008 read  in  1  read strobe, one-cycle request.
REQ-009 write  in  1  write strobe, one-cycle request.
REQ-010 writedata  in  32  write data.
REQ-011 byteenable  in  4  byte lanes for write.
REQ-012 readdata  out  32  registered read data.
REQ-013 readdatavalid  out  1  high for one cycle, exactly 1 cycle after accepted read.

Function
REQ-014 Address map SHALL be: 0 SYSTEM_ID (RO); 1 TIMESTAMP (RO); 2 UPTIME_LO (RO); 3 UPTIME_HI (RO, shadow); 4 CTRL (RW); 5..4+NUM_SCRATCH SCRATCH[n] (RW); all others read 0, writes ignored.
REQ-015 No waitrequest; every read/write SHALL be accepted in the cycle it is asserted.
REQ-016 Read latency SHALL be fixed at 1: readdata/readdatavalid updated on the edge following read=1; readdata holds its last value when readdatavalid=0.
REQ-017 A 64-bit uptime counter SHALL increment by 1 every cycle when CTRL.run=1, wrapping 2^64-1 -> 0 without flag.
REQ-018 A read of word 2 SHALL return counter[31:0] as sampled in the request cycle (pre-increment) and in the same edge load counter[63:32] of that sample into the HI shadow.
REQ-019 A read of word 3 SHALL return the HI shadow, never the live high word; shadow changes only on word-2 reads, clear, or reset.
REQ-020 CTRL bit0 run (reset 1), bit1 clear (write-1 self-clearing, reads 0), bits 31:2 read 0.
REQ-021 Writing CTRL with clear=1 SHALL zero counter and HI shadow on that edge; counter resumes counting next cycle if run=1.
REQ-022 Read of word 2 coincident with clear SHALL not occur (read and write exclusive per REQ-024); counter increment coincident with clear: clear wins.
REQ-023 Scratch and CTRL writes SHALL honour byteenable per lane; byteenable=0 writes nothing.
REQ-024 If read and write are both asserted, the read SHALL be performed and the write dropped.
REQ-025 Writes to RO/unmapped words SHALL have no side effect and produce no readdatavalid.

Reset
REQ-026 On reset: readdata=0, readdatavalid=0, counter=0, HI shadow=0, CTRL.run=1, all SCRATCH=0.
REQ-027 Reset asserted mid-read SHALL suppress the pending readdatavalid; first valid read after release returns post-reset state.
REQ-028 Reset release SHALL be synchronous to clock externally; block takes no action on release beyond resuming counting.

Structure
REQ-029 Shared package sysinfo_pkg SHALL hold word-address constants (ADDR_ID..ADDR_SCRATCH0), CTRL bit indices and reset values.
REQ-030 Counter plus HI shadow SHALL be a sub-module sysinfo_uptime_counter (ports: clock, reset, run, clear, snap, count, hi_shadow).
REQ-031 Register decode and read mux SHALL live in the top module; no memories, flops only.

Verification
REQ-032 Reset then read words 0,1,7 -> readdata 32'h5148_D8C5, TIMESTAMP, 0, each with one-cycle readdatavalid.
REQ-033 Force counter to 64'h0000_0001_FFFF_FFFF, read word 2 then word 3 -> 32'hFFFF_FFFF then 32'h0000_0001 (not 2).
REQ-034 Write CTRL=0 (stop), read word 2 twice 10 cycles apart -> identical values; write CTRL=3 -> subsequent word 2 read small (<5), CTRL reads 1.
REQ-035 Write SCRATCH0=32'hA5A5_A5A5 be=4'hF, then 32'h0000_3C00 be=4'b0010 -> read 32'hA5A5_3CA5.
REQ-036 Assert read and write to SCRATCH0 same cycle -> old data returned, scratch unchanged; reset asserted the cycle after read -> readdatavalid stays 0.
